// File: rtl/byte_operand_fetch.sv
// byte_operand_fetch: 4-byte register bank snapshotted onto the byte mux inputs behind a valid/ready stage.
// Define WB_BYPASS_EN to forward a same-edge writeback into the snapshot.
module byte_operand_fetch #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 8,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [1:0]       wr_addr,
  input  logic [7:0]       wr_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       op_i0,
  output logic [7:0]       op_i1,
  output logic [7:0]       op_i2,
  output logic [7:0]       op_i3,
  output logic             s0,
  output logic             s1,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] stall_cnt
);
  logic [7:0] bank [4];
  logic [7:0] fwd [4];
  logic accept;
  assign in_ready = !out_valid || out_ready;
  assign accept = in_valid && in_ready;
  always_comb begin
    for (int k = 0; k < 4; k++) begin
`ifdef WB_BYPASS_EN
      fwd[k] = (wr_en && wr_addr == 2'(k)) ? wr_data : bank[k];
`else
      fwd[k] = bank[k];
`endif
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) bank[k] <= RST_VAL;
    end else if (wr_en) begin
      bank[wr_addr] <= wr_data;
    end
  end
  // snapshot fields only load on accept, so X on idle inputs never reaches state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      op_i0 <= 8'h00;
      op_i1 <= 8'h00;
      op_i2 <= 8'h00;
      op_i3 <= 8'h00;
      {s1, s0} <= 2'b00;
      out_tag <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      op_i0 <= fwd[0];
      op_i1 <= fwd[1];
      op_i2 <= fwd[2];
      op_i3 <= fwd[3];
      {s1, s0} <= in_sel;
      out_tag <= in_tag;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end
endmodule

// File: tb/tb_byte_operand_fetch.sv
// tb_byte_operand_fetch: directed checks of reset, fetch, sweep, stall, saturation and same-edge writeback.
module tb_byte_operand_fetch;
  logic clk = 0, rst_n = 0;
  logic wr_en = 0, in_valid = 0, out_ready = 0;
  logic [1:0] wr_addr = 0, in_sel = 0;
  logic [7:0] wr_data = 0;
  logic [3:0] in_tag = 0;
  logic in_ready, out_valid, s0, s1;
  logic [7:0] op_i0, op_i1, op_i2, op_i3;
  logic [3:0] out_tag;
  logic [2:0] stall_cnt;
  int checks = 0, failures = 0;

  byte_operand_fetch #(.TAG_W(4), .CNT_W(3), .RST_VAL(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .op_i0(op_i0), .op_i1(op_i1), .op_i2(op_i2), .op_i3(op_i3),
    .s0(s0), .s1(s1), .out_tag(out_tag), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    step();
    wr_en = 0;
  endtask

  initial begin
    #12 rst_n = 1;
    step();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_ops", {op_i3, op_i2, op_i1, op_i0}, 0);
    chk("rst_cnt", 32'(stall_cnt), 0);
    wr(0, 8'hFF); wr(1, 8'h00); wr(2, 8'hAA); wr(3, 8'h0F);
    // single fetch
    in_valid = 1; in_sel = 2'b01; in_tag = 3; out_ready = 1;
    step();
    in_valid = 0;
    chk("fetch_valid", 32'(out_valid), 1);
    chk("fetch_ops", {op_i3, op_i2, op_i1, op_i0}, 32'h0FAA00FF);
    chk("fetch_sel", 32'({s1, s0}), 1);
    chk("fetch_tag", 32'(out_tag), 3);
    // asynchronous reset mid-cycle while a snapshot is held
    out_ready = 0;
    #2 rst_n = 0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_ops", {op_i3, op_i2, op_i1, op_i0}, 0);
    chk("arst_sel_tag", 32'({s1, s0, out_tag}), 0);
    chk("arst_cnt", 32'(stall_cnt), 0);
    #1 rst_n = 1;
    in_valid = 1; in_sel = 2'b11; in_tag = 5; out_ready = 1;
    step();
    in_valid = 0;
    chk("post_rst_bank", {op_i3, op_i2, op_i1, op_i0}, 0);
    chk("post_rst_sel", 32'({s1, s0}), 3);
    wr(0, 8'hFF); wr(1, 8'h00); wr(2, 8'hAA); wr(3, 8'h0F);
    chk("drain_valid", 32'(out_valid), 0);
    // back-to-back sweep
    in_valid = 1;
    in_sel = 2'b00; in_tag = 1; step();
    chk("sw0_vsel", 32'({out_valid, s1, s0, in_ready}), 32'b1001);
    in_sel = 2'b10; in_tag = 2; step();
    chk("sw1_vsel", 32'({out_valid, s1, s0, in_ready}), 32'b1101);
    in_sel = 2'b01; in_tag = 3; step();
    chk("sw2_vsel", 32'({out_valid, s1, s0, in_ready}), 32'b1011);
    in_sel = 2'b11; in_tag = 4; step();
    chk("sw3_vsel", 32'({out_valid, s1, s0, in_ready}), 32'b1111);
    chk("sw3_tag", 32'(out_tag), 4);
    // stall 5 cycles with a pending request and a bank write
    in_sel = 2'b00; in_tag = 9; out_ready = 0;
    wr(2, 8'h55);
    step(); step(); step(); step();
    chk("stall_ready", 32'(in_ready), 0);
    chk("stall_op2", 32'(op_i2), 32'hAA);
    chk("stall_hold", 32'({s1, s0, out_tag}), 32'({2'b11, 4'd4}));
    chk("stall_cnt5", 32'(stall_cnt), 5);
    out_ready = 1;
    step();
    in_valid = 0;
    chk("release_op2", 32'(op_i2), 32'h55);
    chk("release_tag", 32'(out_tag), 9);
    chk("release_cnt", 32'(stall_cnt), 5);
    // X on idle inputs must not reach state
    in_sel = 'x; in_tag = 'x;
    step();
    chk("x_drain", 32'({out_valid, s1, s0}), 0);
    chk("x_tag", 32'(out_tag), 9);
    // same-edge write and accept to r1 (currently 00)
    in_valid = 1; in_sel = 2'b10; in_tag = 6;
    wr(1, 8'h3C);
`ifdef WB_BYPASS_EN
    chk("same_edge_op1", 32'(op_i1), 32'h3C);
`else
    chk("same_edge_op1", 32'(op_i1), 32'h00);
`endif
    in_tag = 7;
    step();
    in_valid = 0;
    chk("next_op1", 32'(op_i1), 32'h3C);
    chk("next_tag", 32'(out_tag), 7);
    // saturation: counter continues from 5 and stops at 7
    out_ready = 0;
    step();
    chk("sat_cnt6", 32'(stall_cnt), 6);
    for (int i = 0; i < 9; i++) step();
    chk("sat_cnt7", 32'(stall_cnt), 7);
    chk("sat_valid", 32'(out_valid), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/byte_operand_fetch.md
Name: byte_operand_fetch

Overview:
- Operand-fetch stage of the 3-stage processor; sits directly upstream of the 4-to-1 byte operand mux.
- Holds a 4-entry byte register bank written by the writeback stage.
- On each accepted fetch request, snapshots all four bytes onto op_i0..op_i3 and drives the mux selects s0/s1 from a pipeline register.
- Uses a valid/ready handshake so the downstream execute stage can stall it.

Parameters:
- TAG_W, 4, width of the instruction tag carried alongside the operands.
- CNT_W, 8, width of the saturating stall-cycle counter.
- RST_VAL, 8'h00, reset value of every bank register.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_en  in  1  writeback strobe.
- wr_addr  in  2  bank register written when wr_en=1.
- wr_data  in  8  writeback byte.
- in_valid  in  1  fetch request valid.
- in_ready  out  1  stage can accept a request this cycle.
- in_sel  in  2  operand select; bit1 drives s1, bit0 drives s0.
- in_tag  in  TAG_W  instruction tag.
- out_valid  out  1  snapshot valid toward the mux/execute stage.
- out_ready  in  1  downstream consumes the snapshot this cycle.
- op_i0..op_i3  out  8 each  snapshot bytes; connect to mux inputs i0..i3.
- s0  out  1  mux select LSB.
- s1  out  1  mux select MSB.
- out_tag  out  TAG_W  tag of the snapshot.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - bank r0..r3 = RST_VAL.
  - out_valid=0, op_i0..op_i3=8'h00, s0=s1=0, out_tag=0, stall_cnt=0.
  - Reset asserted mid-transfer drops any held snapshot; no partial state survives.
- Select mapping, intended mux function: {s1,s0} = 00 picks i0, 01 picks i1, 10 picks i2, 11 picks i3.
- Bank write: on clk edge with wr_en=1, r[wr_addr] <= wr_data. Writes are independent of the handshake and are never blocked.
- in_ready = !out_valid || out_ready (combinational).
- Accept = in_valid && in_ready. On accept at edge:
  - out_valid <= 1.
  - op_ik <= r[k] for k=0..3.
  - {s1,s0} <= in_sel.
  - out_tag <= in_tag.
  - Latency: request to out_valid is 1 cycle.
- Drain: out_valid && out_ready && !in_valid clears out_valid at the edge. Snapshot data and selects hold their last values.
- Hold: out_valid && !out_ready keeps op_i*, s0, s1 and out_tag stable. A bank write during the hold does NOT alter the held snapshot.
- Back-to-back: out_ready=1 with in_valid=1 every cycle gives one transfer per cycle with no bubble.
- stall_cnt increments each cycle out_valid && !out_ready and saturates at all-ones; it never wraps. Cleared only by reset.
- Simultaneous accept and write to the same register: handled per the optional feature below.
- X on in_sel or in_tag when in_valid=0 must not propagate into state.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: on the accept edge, if wr_en=1 and wr_addr=k, op_ik captures wr_data (writeback forwarding). The bank is also updated.
- Undefined: op_ik captures the pre-write value of r[k]. The new value is visible only to requests accepted on later edges.

Test Plan:
- Reset: write r0..r3 = FF,00,AA,0F, then pulse rst_n low mid-cycle -> all outputs 0 immediately (async), bank back to 00.
- Fetch: load FF,00,AA,0F; request in_sel=2'b01, tag=3, out_ready=1 -> next cycle out_valid=1, op_i0..3=FF,00,AA,0F, s1=0, s0=1, out_tag=3.
- Sweep: back-to-back in_sel=00,10,01,11 with out_ready=1 -> four consecutive valid cycles with {s1,s0} matching each request, in_ready stays 1.
- Stall: out_ready=0 for 5 cycles while out_valid=1, writing r2=55 during the stall:
  - in_ready=0; op_i2 stays AA; stall_cnt=5.
  - Next accepted request after release sees op_i2=55.
- Saturation: CNT_W=3, hold stall for 10 cycles -> stall_cnt stops at 7.
- Same-edge write/accept: r1=00, wr_en=1, wr_addr=1, wr_data=3C coincident with accept:
  - With WB_BYPASS_EN: op_i1=3C.
  - Without WB_BYPASS_EN: op_i1=00, and the following request sees 3C.
